// File: rtl/leaf_user_in_buffer_pkg.sv
// Shared constants and helpers for the leaf user-side input buffer.
package leaf_user_in_buffer_pkg;

   // Default payload word width, matching the leaf interface.
   localparam int PAYLOAD_BITS_DEFAULT = 32;

   // Number of buffer entries for a given pointer width.
   function automatic int depth_of(input int depth_bits);
      return 1 << depth_bits;
   endfunction

endpackage

// File: rtl/leaf_user_in_buffer_if.sv
// Handshake bundle between leaf_interface, the input buffer and the user operator.
// Upstream side is vld/ack from the interface; downstream side is valid/ready to the operator.
interface leaf_user_in_buffer_if
   import leaf_user_in_buffer_pkg::*;
#(
   parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT
);

   logic [PAYLOAD_BITS-1:0] din_leaf_interface2user;
   logic                    vld_interface2user;
   logic                    ack_user2interface;
   logic [PAYLOAD_BITS-1:0] dout_buf2user;
   logic                    vld_buf2user;
   logic                    rdy_user2buf;

   // Environment view: drives the incoming words and the operator ready.
   modport master (
      output din_leaf_interface2user,
      output vld_interface2user,
      output rdy_user2buf,
      input  ack_user2interface,
      input  dout_buf2user,
      input  vld_buf2user
   );

   // Buffer view.
   modport slave (
      input  din_leaf_interface2user,
      input  vld_interface2user,
      input  rdy_user2buf,
      output ack_user2interface,
      output dout_buf2user,
      output vld_buf2user
   );

endinterface

// File: rtl/leaf_user_in_buffer_mem.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
module leaf_user_in_buffer_mem
   import leaf_user_in_buffer_pkg::*;
#(
   parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT,
   parameter int DEPTH_BITS   = 4
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [DEPTH_BITS-1:0]   wr_addr,
   input  logic [PAYLOAD_BITS-1:0] wr_data,
   input  logic [DEPTH_BITS-1:0]   rd_addr,
   output logic [PAYLOAD_BITS-1:0] rd_data
);

   localparam int DEPTH = depth_of(DEPTH_BITS);

   logic [PAYLOAD_BITS-1:0] mem [DEPTH];

   // Storage is not reset; contents are only observed behind a valid fill count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/leaf_user_in_buffer.sv
// Elastic receive buffer between a leaf_interface user-side output and the user operator.
// Pointers wrap silently; full/empty is decided by fill_count alone.
module leaf_user_in_buffer
   import leaf_user_in_buffer_pkg::*;
#(
   parameter int PAYLOAD_BITS       = PAYLOAD_BITS_DEFAULT,
   parameter int DEPTH_BITS         = 4,
   parameter int ALMOST_FULL_MARGIN = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   leaf_user_in_buffer_if.slave  bus,
   output logic [DEPTH_BITS:0]   fill_count,
   output logic                  almost_full,
   output logic [31:0]           word_count
);

   localparam int                  DEPTH      = depth_of(DEPTH_BITS);
   localparam logic [DEPTH_BITS:0] DEPTH_CNT  = (DEPTH_BITS + 1)'(DEPTH);
   localparam logic [DEPTH_BITS:0] MARGIN_CNT = (DEPTH_BITS + 1)'(ALMOST_FULL_MARGIN);

   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic                  push;
   logic                  pop;

   // No bypass when full: a pop in the same cycle does not reopen ack.
   assign bus.ack_user2interface = !reset && (fill_count != DEPTH_CNT);
   assign bus.vld_buf2user       = (fill_count != '0);
   assign almost_full            = ((DEPTH_CNT - fill_count) <= MARGIN_CNT);

   assign push = bus.vld_interface2user && bus.ack_user2interface;
   assign pop  = bus.vld_buf2user && bus.rdy_user2buf;

   // Pointer, occupancy and accepted-word bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_count <= '0;
         word_count <= '0;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 32'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            fill_count <= fill_count + 1'b1;
         end else if (pop && !push) begin
            fill_count <= fill_count - 1'b1;
         end
      end
   end

   leaf_user_in_buffer_mem #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .DEPTH_BITS   (DEPTH_BITS)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (bus.din_leaf_interface2user),
      .rd_addr (rd_ptr),
      .rd_data (bus.dout_buf2user)
   );

endmodule

// File: tb/tb_leaf_user_in_buffer.sv
// Directed bench for leaf_user_in_buffer with a FIFO scoreboard for ordering.
module tb_leaf_user_in_buffer;
   import leaf_user_in_buffer_pkg::*;

   logic        clk;
   logic        reset;
   logic [4:0]  fill_count;
   logic        almost_full;
   logic [31:0] word_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] q[$];
   logic [31:0] wc_exp;

   leaf_user_in_buffer_if #(.PAYLOAD_BITS(32)) bus ();

   leaf_user_in_buffer #(
      .PAYLOAD_BITS       (32),
      .DEPTH_BITS         (4),
      .ALMOST_FULL_MARGIN (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .fill_count  (fill_count),
      .almost_full (almost_full),
      .word_count  (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: apply inputs, check state against the scoreboard, advance.
   task automatic step(input logic v, input logic [31:0] d, input logic r, output logic acked);
      logic vld_e;
      logic ack_e;
      bus.vld_interface2user      = v;
      bus.din_leaf_interface2user = d;
      bus.rdy_user2buf            = r;
      #1;
      vld_e = (q.size() != 0);
      ack_e = (q.size() != 16);
      chk("fill", 32'(fill_count), 32'(q.size()));
      chk("vld", 32'(bus.vld_buf2user), 32'(vld_e));
      chk("ack", 32'(bus.ack_user2interface), 32'(ack_e));
      chk("afull", 32'(almost_full), 32'((16 - q.size()) <= 2));
      chk("wcount", word_count, wc_exp);
      acked = bus.ack_user2interface;
      if (vld_e && r) begin
         chk("dout", bus.dout_buf2user, q[0]);
         void'(q.pop_front());
      end
      if (v && ack_e) begin
         q.push_back(d);
         wc_exp = wc_exp + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.vld_interface2user = 1'b1;
      bus.rdy_user2buf       = 1'b1;
      reset                  = 1'b1;
      #1;
      chk("rst_ack", 32'(bus.ack_user2interface), 32'd0);
      @(negedge clk);
      reset                  = 1'b0;
      bus.vld_interface2user = 1'b0;
      bus.rdy_user2buf       = 1'b0;
      #1;
      chk("rst_fill", 32'(fill_count), 32'd0);
      chk("rst_vld", 32'(bus.vld_buf2user), 32'd0);
      chk("rst_wcount", word_count, 32'd0);
      chk("rst_afull", 32'(almost_full), 32'd0);
      chk("rst_ack_after", 32'(bus.ack_user2interface), 32'd1);
      q.delete();
      wc_exp = 32'd0;
   endtask

   initial begin
      logic a;
      int   acks;
      int   af_fill;
      int   guard;

      reset                       = 1'b1;
      bus.vld_interface2user      = 1'b0;
      bus.rdy_user2buf            = 1'b0;
      bus.din_leaf_interface2user = '0;
      wc_exp                      = 32'd0;
      repeat (2) @(negedge clk);
      do_reset();

      // Basic latency: word visible the cycle after it is pushed.
      step(1'b1, 32'hDEADBEEF, 1'b1, a);
      chk("lat_vld", 32'(bus.vld_buf2user), 32'd1);
      chk("lat_dout", bus.dout_buf2user, 32'hDEADBEEF);
      step(1'b0, 32'h0, 1'b1, a);
      step(1'b0, 32'h0, 1'b0, a);
      chk("lat_wcount", word_count, 32'd1);

      // Fill to full with data 1..20 and the operator stalled.
      acks    = 0;
      af_fill = -1;
      for (int i = 1; i <= 20; i++) begin
         if (almost_full && af_fill < 0) af_fill = int'(fill_count);
         step(1'b1, 32'(i), 1'b0, a);
         if (a) acks++;
      end
      chk("full_acks", 32'(acks), 32'd16);
      chk("full_fill", 32'(fill_count), 32'd16);
      chk("af_first", 32'(af_fill), 32'd14);

      // Full with pop: the offered word is refused, then accepted next cycle.
      step(1'b1, 32'd21, 1'b1, a);
      chk("fullpop_ack", 32'(a), 32'd0);
      chk("fullpop_fill", 32'(fill_count), 32'd15);
      step(1'b1, 32'd21, 1'b0, a);
      chk("fullpop_ack2", 32'(a), 32'd1);
      for (int i = 2; i <= 16; i++) begin
         chk("order", bus.dout_buf2user, 32'(i));
         step(1'b0, 32'h0, 1'b1, a);
      end
      chk("order_last", bus.dout_buf2user, 32'd21);
      step(1'b0, 32'h0, 1'b1, a);
      step(1'b0, 32'h0, 1'b0, a);

      // Streaming 0..99 with both sides always ready.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 32'(i), 1'b1, a);
      end
      step(1'b0, 32'h0, 1'b1, a);
      step(1'b0, 32'h0, 1'b0, a);
      chk("stream_wcount", word_count, 32'd100);

      // Wrap-around: bursts of 10 in, 10 out with random ready gaps.
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h1000 + 32'(r * 10 + i), 1'b0, a);
         end
         guard = 0;
         while (q.size() != 0 && guard < 200) begin
            step(1'b0, 32'h0, 1'($urandom_range(0, 1)), a);
            guard++;
         end
         chk("wrap_drained", 32'(q.size()), 32'd0);
      end
      step(1'b0, 32'h0, 1'b0, a);
      chk("wrap_wcount", word_count, 32'd150);

      // Reset mid-stream discards buffered words.
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 32'h100 + 32'(i), 1'b0, a);
      end
      chk("pre_rst_fill", 32'(fill_count), 32'd7);
      do_reset();
      step(1'b1, 32'hA5A50001, 1'b0, a);
      chk("post_rst_dout", bus.dout_buf2user, 32'hA5A50001);
      step(1'b0, 32'h0, 1'b1, a);
      step(1'b0, 32'h0, 1'b0, a);
      chk("post_rst_wcount", word_count, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
